// File: rtl/cdb_pkg.sv
// Shared definitions for the common data bus scheduler and its bus users.
package cdb_pkg;

  localparam int CDB_COUNT  = 2;
  localparam int CDB_ADDR_W = 8;

  typedef logic [CDB_ADDR_W-1:0] cdb_addr_t;

  // Never handed to a requester, so arbiters can treat it as "bus unused".
  localparam cdb_addr_t IDLE_SELECT = 8'hFF;

endpackage

// File: rtl/cdb_if.sv
// Scheduler <-> result-producing combos: requests in, bus select/grant out.
interface cdb_if #(
  parameter int NUM_REQ = 8
);
  import cdb_pkg::*;

  logic [NUM_REQ-1:0]   req;
  cdb_addr_t            select0;
  cdb_addr_t            select1;
  logic [NUM_REQ-1:0]   grant0;
  logic [NUM_REQ-1:0]   grant1;
  logic [CDB_COUNT-1:0] bus_busy;

  modport master (
    input  req,
    output select0, select1, grant0, grant1, bus_busy
  );

  modport slave (
    output req,
    input  select0, select1, grant0, grant1, bus_busy
  );

endinterface

// File: rtl/rr_dual_picker.sv
// Combinational round-robin picker returning the first two set bits of elig,
// scanning upward from rr_ptr with wrap.
module rr_dual_picker #(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             pick0_vld,
  output logic [IDX_W-1:0] pick0_idx,
  output logic             pick1_vld,
  output logic [IDX_W-1:0] pick1_idx
);

  function automatic logic [IDX_W-1:0] wrap_add(logic [IDX_W-1:0] base, int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IDX_W'(s);
  endfunction

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off0;
  logic [IDX_W-1:0] off1;

  always_comb begin
    rot = '0;
    for (int k = 0; k < N; k++) begin
      rot[k] = elig[wrap_add(rr_ptr, k)];
    end

    pick0_vld = 1'b0;
    pick1_vld = 1'b0;
    off0      = '0;
    off1      = '0;
    for (int k = 0; k < N; k++) begin
      if (rot[k]) begin
        if (!pick0_vld) begin
          pick0_vld = 1'b1;
          off0      = IDX_W'(k);
        end else if (!pick1_vld) begin
          pick1_vld = 1'b1;
          off1      = IDX_W'(k);
        end
      end
    end

    pick0_idx = wrap_add(rr_ptr, int'(off0));
    pick1_idx = wrap_add(rr_ptr, int'(off1));
  end

endmodule

// File: rtl/cdb_scheduler.sv
// Grants up to two requesting combos one common data bus each per cycle,
// rotating priority, with registered select addresses and grant vectors.
module cdb_scheduler
  import cdb_pkg::*;
#(
  parameter int        NUM_REQ   = 8,
  parameter cdb_addr_t ADDR_BASE = 8'h01,
  parameter int        ADDR_W    = CDB_ADDR_W
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  cdb_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  typedef logic [IDX_W-1:0] idx_t;

  if (NUM_REQ < 2 || NUM_REQ > 254 || ADDR_W != CDB_ADDR_W ||
      int'(ADDR_BASE) + NUM_REQ - 1 >= int'(IDLE_SELECT)) begin : g_bad_params
    $error("cdb_scheduler: illegal NUM_REQ/ADDR_BASE/ADDR_W combination");
  end

  cdb_addr_t            sel0_q, sel0_d, sel1_q, sel1_d;
  logic [NUM_REQ-1:0]   grant0_q, grant0_d, grant1_q, grant1_d;
  logic [CDB_COUNT-1:0] busy_q, busy_d;
  idx_t                 rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] elig;
  logic               pick0_vld, pick1_vld;
  idx_t               pick0_idx, pick1_idx;

  function automatic idx_t next_ptr(idx_t i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Last cycle's winners sit out one cycle so they can drop or refresh req.
  assign elig = bus.req & ~(grant0_q | grant1_q);

  rr_dual_picker #(.N(NUM_REQ)) u_picker (
    .elig      (elig),
    .rr_ptr    (rr_ptr_q),
    .pick0_vld (pick0_vld),
    .pick0_idx (pick0_idx),
    .pick1_vld (pick1_vld),
    .pick1_idx (pick1_idx)
  );

  always_comb begin
    sel0_d   = IDLE_SELECT;
    sel1_d   = IDLE_SELECT;
    grant0_d = '0;
    grant1_d = '0;
    busy_d   = '0;
    rr_ptr_d = rr_ptr_q;
    if (!clear) begin
      if (pick0_vld) begin
        sel0_d              = ADDR_BASE + cdb_addr_t'(pick0_idx);
        grant0_d[pick0_idx] = 1'b1;
        busy_d[0]           = 1'b1;
        rr_ptr_d            = next_ptr(pick0_idx);
      end
      if (pick1_vld) begin
        sel1_d              = ADDR_BASE + cdb_addr_t'(pick1_idx);
        grant1_d[pick1_idx] = 1'b1;
        busy_d[1]           = 1'b1;
        rr_ptr_d            = next_ptr(pick1_idx);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel0_q   <= IDLE_SELECT;
      sel1_q   <= IDLE_SELECT;
      grant0_q <= '0;
      grant1_q <= '0;
      busy_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      sel0_q   <= sel0_d;
      sel1_q   <= sel1_d;
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.select0  = sel0_q;
  assign bus.select1  = sel1_q;
  assign bus.grant0   = grant0_q;
  assign bus.grant1   = grant1_q;
  assign bus.bus_busy = busy_q;

  a_disjoint: assert property (@(posedge clock) disable iff (!reset)
    (grant0_q & grant1_q) == '0);
  a_bus0_first: assert property (@(posedge clock) disable iff (!reset)
    (grant1_q != '0) |-> (grant0_q != '0));
  a_onehot: assert property (@(posedge clock) disable iff (!reset)
    $onehot0(grant0_q) && $onehot0(grant1_q));

endmodule

// File: tb/tb_cdb_scheduler.sv
// Scoreboarded bench for cdb_scheduler: a reference model predicts each
// cycle's grants when req is driven; results are compared after the edge.
module tb_cdb_scheduler;
  import cdb_pkg::*;

  localparam int        N    = 8;
  localparam cdb_addr_t BASE = 8'h01;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  cdb_if #(.NUM_REQ(N)) bus ();

  cdb_scheduler #(.NUM_REQ(N), .ADDR_BASE(BASE), .ADDR_W(8)) dut (
    .clock (clk),
    .reset (rst_n),
    .clear (clear),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    cdb_addr_t    s0;
    cdb_addr_t    s1;
    logic [N-1:0] g0;
    logic [N-1:0] g1;
    logic [1:0]   busy;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  int           m_ptr;
  logic [N-1:0] m_g0, m_g1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_g0  = '0;
    m_g1  = '0;
  endtask

  task automatic predict(input logic [N-1:0] r, input logic c, output exp_t e);
    logic [N-1:0] el;
    int hits, last, i;
    e.s0 = IDLE_SELECT; e.s1 = IDLE_SELECT;
    e.g0 = '0; e.g1 = '0; e.busy = '0;
    hits = 0; last = 0;
    if (!c) begin
      el = r & ~(m_g0 | m_g1);
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (el[i] && hits < 2) begin
          if (hits == 0) begin
            e.g0[i] = 1'b1; e.s0 = BASE + cdb_addr_t'(i); e.busy[0] = 1'b1;
          end else begin
            e.g1[i] = 1'b1; e.s1 = BASE + cdb_addr_t'(i); e.busy[1] = 1'b1;
          end
          hits++;
          last = i;
        end
      end
      if (hits > 0) m_ptr = (last + 1) % N;
    end
    m_g0 = e.g0;
    m_g1 = e.g1;
  endtask

  // Called just after a rising edge (or mid-cycle); returns just after the next one.
  task automatic step(input string tag, input logic [N-1:0] r, input logic c);
    exp_t e;
    bus.req = r;
    clear   = c;
    predict(r, c, e);
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".select0"},  32'(bus.select0),  32'(e.s0));
    chk({tag, ".select1"},  32'(bus.select1),  32'(e.s1));
    chk({tag, ".grant0"},   32'(bus.grant0),   32'(e.g0));
    chk({tag, ".grant1"},   32'(bus.grant1),   32'(e.g1));
    chk({tag, ".bus_busy"}, 32'(bus.bus_busy), 32'(e.busy));
    clear = 1'b0;
  endtask

  task automatic apply_reset();
    bus.req = '0;
    clear   = 1'b0;
    rst_n   = 1'b0;
    #2;
    rst_n   = 1'b1;
    model_reset();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".select0"},  32'(bus.select0),  32'(8'hFF));
    chk({tag, ".select1"},  32'(bus.select1),  32'(8'hFF));
    chk({tag, ".grant0"},   32'(bus.grant0),   32'h0);
    chk({tag, ".grant1"},   32'(bus.grant1),   32'h0);
    chk({tag, ".bus_busy"}, 32'(bus.bus_busy), 32'h0);
  endtask

  int           cnt [N];
  int           wait_c [N];
  int           max_wait;
  logic [N-1:0] rq, granted;

  initial begin
    // T1: reset held low with every requester active
    bus.req = '1;
    model_reset();
    #12;
    chk_idle("t1_a");
    @(posedge clk); #1;
    chk_idle("t1_b");
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // T2: single requester, masked every other cycle
    step("t2_c1", 8'h04, 1'b0);
    chk("t2_c1.sel0_abs", 32'(bus.select0), 32'h03);
    step("t2_c2", 8'h04, 1'b0);
    chk("t2_c2.busy_abs", 32'(bus.bus_busy), 32'h0);
    step("t2_c3", 8'h04, 1'b0);
    chk("t2_c3.grant0_abs", 32'(bus.grant0), 32'h04);

    // T3: full contention, rotation and wrap
    apply_reset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < 40; c++) begin
      step("t3", 8'hFF, 1'b0);
      granted = bus.grant0 | bus.grant1;
      for (int i = 0; i < N; i++) if (granted[i]) cnt[i]++;
      if (c == 3) chk("t3_c3.pair_67", 32'(granted), 32'hC0);
      if (c == 4) chk("t3_c4.wrap_01", 32'(granted), 32'h03);
    end
    for (int i = 0; i < N; i++) chk($sformatf("t3_count%0d", i), 32'(cnt[i]), 32'd10);

    // T4: clear flushes the decision but keeps the pointer
    apply_reset();
    step("t4_pre", 8'h02, 1'b0);
    step("t4_clr", 8'h81, 1'b1);
    chk("t4_clr.busy_abs", 32'(bus.bus_busy), 32'h0);
    step("t4_post", 8'h81, 1'b0);
    chk("t4_post.sel0_abs", 32'(bus.select0), 32'h08);
    chk("t4_post.sel1_abs", 32'(bus.select1), 32'h01);

    // T5: asynchronous reset between edges while both buses are busy
    apply_reset();
    step("t5_pre", 8'hFF, 1'b0);
    chk("t5_pre.busy_abs", 32'(bus.bus_busy), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("t5_async");
    #1;
    rst_n = 1'b1;
    model_reset();
    step("t5_post", 8'h81, 1'b0);
    chk("t5_post.sel0_abs", 32'(bus.select0), 32'h01);
    chk("t5_post.sel1_abs", 32'(bus.select1), 32'h08);

    // T6: random level-sensitive traffic, requesters hold req until granted
    apply_reset();
    rq = '0;
    max_wait = 0;
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      step("t6", rq, 1'b0);
      granted = bus.grant0 | bus.grant1;
      for (int i = 0; i < N; i++) begin
        if (rq[i]) begin
          wait_c[i]++;
          if (wait_c[i] > max_wait) max_wait = wait_c[i];
          if (granted[i]) wait_c[i] = 0;
        end else begin
          wait_c[i] = 0;
        end
        if (!(rq[i] && !granted[i])) rq[i] = ($urandom_range(0, 1) == 1);
      end
    end
    chk("t6_max_wait_ok", 32'(max_wait <= N/2 + 1), 32'h1);
    chk("sb_empty", 32'(q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
